// File: rtl/cc1200_apb_master.sv
// Command/response to APB requester bridge. It runs one transfer at a time with an
// optional wait-state timeout and a saturating error counter.
module cc1200_apb_master #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        rsp_timeout,
    output logic [31:0] APB_M_0_paddr,
    output logic        APB_M_0_psel,
    output logic        APB_M_0_penable,
    output logic        APB_M_0_pwrite,
    output logic [31:0] APB_M_0_pwdata,
    input  logic [31:0] APB_M_0_prdata,
    input  logic        APB_M_0_pready,
    input  logic        APB_M_0_pslverr,
    output logic [15:0] err_count
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;

    localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);
    localparam bit          TIMEOUT_EN    = (TIMEOUT_CYCLES != 0);

    state_e      state_q, state_d;
    logic        cmd_ready_q, cmd_ready_d;
    logic [31:0] paddr_q, paddr_d;
    logic [31:0] pwdata_q, pwdata_d;
    logic        pwrite_q, pwrite_d;
    logic        psel_q, psel_d;
    logic        penable_q, penable_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;
    logic        rsp_timeout_q, rsp_timeout_d;
    logic [15:0] err_count_q, err_count_d;
    logic [15:0] wait_cnt_q, wait_cnt_d;
    logic [15:0] wait_inc;

    assign wait_inc = wait_cnt_q + 16'd1;

    always_comb begin
        // NOTE: every _d takes its hold value first so no path through the case infers a latch.
        state_d       = state_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        pwrite_d      = pwrite_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;
        wait_cnt_d    = wait_cnt_q;
        err_count_d   = err_count_q;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    paddr_d    = cmd_addr;
                    pwdata_d   = cmd_wdata;
                    pwrite_d   = cmd_write;
                    psel_d     = 1'b1;
                    penable_d  = 1'b0;
                    wait_cnt_d = 16'd0;
                    state_d    = SETUP;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                state_d   = ACCESS;
            end
            ACCESS: begin
                // A completing pready wins over a timeout expiring on the same cycle.
                if (APB_M_0_pready) begin
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = pwrite_q ? 32'd0 : APB_M_0_prdata;
                    rsp_err_d     = APB_M_0_pslverr;
                    rsp_timeout_d = 1'b0;
                    state_d       = RESP;
                end else if (TIMEOUT_EN && (wait_inc == TIMEOUT_LIMIT)) begin
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = 32'd0;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                    wait_cnt_d    = wait_inc;
                    state_d       = RESP;
                end else if (wait_cnt_q != 16'hFFFF) begin
                    wait_cnt_d = wait_inc;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if ((state_q == ACCESS) && (state_d == RESP) && rsp_err_d && (err_count_q != 16'hFFFF)) begin
            err_count_d = err_count_q + 16'd1;
        end
    end

    // cmd_ready is registered, so it first rises on the edge that lands in IDLE.
    assign cmd_ready_d = (state_d == IDLE);

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
        if (rst) begin
            state_q       <= IDLE;
            cmd_ready_q   <= 1'b0;
            paddr_q       <= 32'd0;
            pwdata_q      <= 32'd0;
            pwrite_q      <= 1'b0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= 32'd0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            err_count_q   <= 16'd0;
            wait_cnt_q    <= 16'd0;
        end else begin
            state_q       <= state_d;
            cmd_ready_q   <= cmd_ready_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            pwrite_q      <= pwrite_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
            err_count_q   <= err_count_d;
            wait_cnt_q    <= wait_cnt_d;
        end
    end

    assign cmd_ready       = cmd_ready_q;
    assign rsp_valid       = rsp_valid_q;
    assign rsp_rdata       = rsp_rdata_q;
    assign rsp_err         = rsp_err_q;
    assign rsp_timeout     = rsp_timeout_q;
    assign APB_M_0_paddr   = paddr_q;
    assign APB_M_0_psel    = psel_q;
    assign APB_M_0_penable = penable_q;
    assign APB_M_0_pwrite  = pwrite_q;
    assign APB_M_0_pwdata  = pwdata_q;
    assign err_count       = err_count_q;

endmodule

// File: doc/cc1200_apb_master.md
CC1200_APB_MASTER -- requirements
Module: cc1200_apb_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, consecutive ACCESS cycles without pready before abort (0 = timeout disabled, max 65535).
REQ-002 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port cmd_valid  input  1  command request.
REQ-005 SHALL have port cmd_ready  output  1  command accepted when cmd_valid && cmd_ready.
REQ-006 SHALL have port cmd_write  input  1  1 = write, 0 = read.
REQ-007 SHALL have port cmd_addr  input  32  target address.
REQ-008 SHALL have port cmd_wdata  input  32  write data.
REQ-009 SHALL have port rsp_valid  output  1  response available.
REQ-010 SHALL have port rsp_ready  input  1  response consumed when rsp_valid && rsp_ready.
REQ-011 SHALL have port rsp_rdata  output  32  read data (0 for writes and timeouts).
REQ-012 SHALL have port rsp_err  output  1  pslverr seen or timeout.
REQ-013 SHALL have port rsp_timeout  output  1  transfer aborted by timeout.
REQ-014 SHALL have ports APB_M_0_paddr output 32, APB_M_0_psel output 1, APB_M_0_penable output 1, APB_M_0_pwrite output 1, APB_M_0_pwdata output 32: APB requester signals.
REQ-015 SHALL have ports APB_M_0_prdata input 32, APB_M_0_pready input 1, APB_M_0_pslverr input 1: APB completer signals.
REQ-016 SHALL have port err_count  output  16  saturating count of responses with rsp_err=1.

Function
REQ-017 SHALL implement states IDLE, SETUP, ACCESS, RESP; all outputs registered (cmd_ready = 1 exactly in IDLE).
REQ-018 SHALL, in IDLE on cmd_valid, latch cmd_addr/cmd_wdata/cmd_write into paddr/pwdata/pwrite and enter SETUP next cycle.
REQ-019 SHALL drive psel=1, penable=0 for exactly one SETUP cycle, then psel=1, penable=1 in ACCESS.
REQ-020 SHALL hold paddr, pwrite, pwdata stable from SETUP through the last ACCESS cycle.
REQ-021 SHALL, in ACCESS, complete when pready=1 is sampled: capture prdata (reads only, else 0) and pslverr, deassert psel/penable next cycle, enter RESP.
REQ-022 SHALL ignore pready and pslverr in IDLE, SETUP and RESP (completer may hold pready one cycle after psel drops).
REQ-023 SHALL count consecutive ACCESS cycles with pready=0 in a 16-bit counter cleared on entry to SETUP.
REQ-024 SHALL, when TIMEOUT_CYCLES!=0 and that count reaches TIMEOUT_CYCLES, abort: drop psel/penable, rsp_err=1, rsp_timeout=1, rsp_rdata=0, enter RESP.
REQ-025 SHALL give pready=1 priority over timeout when both occur on the same cycle.
REQ-026 SHALL hold rsp_valid and response fields stable in RESP until rsp_ready=1, then return to IDLE next cycle.
REQ-027 SHALL not accept a new command on the cycle leaving RESP (cmd_ready rises one cycle after handshake).
REQ-028 SHALL increment err_count by 1 on entry to RESP with rsp_err=1, saturating at 0xFFFF.
REQ-029 SHALL yield minimum latency cmd accept -> rsp_valid of 3 cycles with zero-wait-state completer.
REQ-030 SHALL never assert penable without psel, nor psel in IDLE or RESP.

Reset
REQ-031 SHALL, with rst=1 on a rising edge, enter IDLE and force cmd_ready=0 during reset, then 1 after first non-reset edge.
REQ-032 SHALL reset psel, penable, pwrite, rsp_valid, rsp_err, rsp_timeout to 0, paddr/pwdata/rsp_rdata to 0, err_count to 0, timeout counter to 0.
REQ-033 SHALL abandon any transfer on reset mid-operation, dropping psel/penable on the same edge; no response is produced.

Verification
REQ-034 Write 0x0000000B to addr 0x00 with one-wait completer (pready one cycle after penable) -> SETUP 1 cycle, ACCESS 2 cycles, rsp_valid with rsp_err=0, err_count=0.
REQ-035 Read addr 0x14 with completer returning 0x00001234 -> rsp_rdata=0x00001234, rsp_err=0; late pready pulse after psel drop ignored, no second transfer.
REQ-036 Read with pslverr=1 at completion -> rsp_err=1, rsp_timeout=0, err_count=1.
REQ-037 pready held 0, TIMEOUT_CYCLES=16 -> abort after 16 ACCESS cycles, rsp_timeout=1, rsp_rdata=0, psel=0 next cycle; pready=1 on cycle 16 -> normal completion.
REQ-038 rsp_ready held 0 for 5 cycles with cmd_valid=1 -> response stable, cmd_ready=0, no APB activity; reset asserted during ACCESS -> psel=0, rsp_valid=0 next cycle.
REQ-039 Force err_count to 0xFFFF via 65535 timeouts (or back-door) then one more error -> err_count stays 0xFFFF.
